// File: rtl/ysyx_25030077_mem_resp_pkg.sv
// ysyx_25030077_mem_resp_pkg: FSM state encoding, default base address and byte-mask width for the memory responder
package ysyx_25030077_mem_resp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam logic [31:0] DEF_ADDR_BASE = 32'h8000_0000;
    localparam int MASK_W = 4;
endpackage

// File: rtl/ysyx_25030077_mem_resp_if.sv
// ysyx_25030077_mem_resp_if: request/response bus; master = requester (core/bench), slave = memory responder
interface ysyx_25030077_mem_resp_if;
    import ysyx_25030077_mem_resp_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_25030077_mem_array.sv
// ysyx_25030077_mem_array: single-port word array with byte-mask writes and registered read data
// Ports: clock; en (access strobe), we (1 = write), idx (word index), wdata, wmask (byte enables), rdata (registered)
module ysyx_25030077_mem_array
    import ysyx_25030077_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [31:0]       wdata,
    input  logic [MASK_W-1:0] wmask,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < MASK_W; b++)
                    if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end else begin
                rdata <= mem[idx];
            end
        end
    end
endmodule

// File: rtl/ysyx_25030077_mem_resp.sv
// ysyx_25030077_mem_resp: one-at-a-time memory responder with programmable latency and range/alignment errors
// Ports: clock; reset (async, active-low); bus (slave side of the request/response interface)
module ysyx_25030077_mem_resp
    import ysyx_25030077_mem_resp_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input logic                      clock,
    input logic                      reset,
    ysyx_25030077_mem_resp_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // 33-bit end address so the upper bound never wraps
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be in 1..15");
    end
    if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of two");
    end
    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              wen_q, err_q, rd_q;
    logic [31:0]       addr_q, wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              acc, a_wen, a_err;
    logic [31:0]       a_addr, a_wdata, arr_rdata;
    logic [MASK_W-1:0] a_wmask;
    logic [IDX_W-1:0]  a_idx;
    // With LATENCY=1 the access happens on the accept edge, so operands come straight from the bus
    assign a_wen   = state == IDLE ? bus.req_wen   : wen_q;
    assign a_addr  = state == IDLE ? bus.req_addr  : addr_q;
    assign a_wdata = state == IDLE ? bus.req_wdata : wdata_q;
    assign a_wmask = state == IDLE ? bus.req_wmask : wmask_q;
    assign acc = reset && ((state == IDLE && bus.req_valid && LATENCY == 1) || (state == WAIT && cnt == 4'd1));
    assign a_err = a_addr < ADDR_BASE || {1'b0, a_addr} >= ADDR_END || a_addr[1:0] != 2'b00;
    assign a_idx = IDX_W'((a_addr - ADDR_BASE) >> 2);
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_nx = LATENCY == 1 ? RESP : WAIT;
                cnt_nx   = 4'(LATENCY - 1);
            end
            WAIT: begin
                cnt_nx   = cnt - 4'd1;
                state_nx = cnt == 4'd1 ? RESP : WAIT;
            end
            RESP: state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.req_valid) begin
                wen_q   <= bus.req_wen;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wmask_q <= bus.req_wmask;
            end
            if (acc) begin
                err_q <= a_err;
                rd_q  <= !a_err && !a_wen;
            end
        end
    end
    ysyx_25030077_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clock (clock),
        .en    (acc && !a_err),
        .we    (a_wen),
        .idx   (a_idx),
        .wdata (a_wdata),
        .wmask (a_wmask),
        .rdata (arr_rdata)
    );
    assign bus.req_ready = reset && state == IDLE;
    assign bus.rsp_valid = state == RESP;
    // The array holds its read register outside accesses, so gating by rd_q keeps rdata stable and zero for stores/errors
    assign bus.rsp_rdata = state == RESP && rd_q ? arr_rdata : 32'd0;
    assign bus.rsp_err   = state == RESP && err_q;
endmodule

// File: tb/tb_ysyx_25030077_mem_resp.sv
// tb_ysyx_25030077_mem_resp: scoreboard bench over three responders built with LATENCY 2, 1 and 15
module tb_ysyx_25030077_mem_resp;
    localparam logic [31:0] BASE = 32'h8000_0000;
    logic clock, reset;
    logic [2:0] rv, wen, rr, rq_rdy, rs_v, rs_e;
    logic [2:0][31:0] addr, wdata, rs_d;
    logic [2:0][3:0] wmask;
    logic [32:0] q[$];
    logic [31:0] mdl [3][16];
    int chk_cnt = 0, pass_cnt = 0;

    initial clock = 0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g == 0 ? 2 : g == 1 ? 1 : 15;
        ysyx_25030077_mem_resp_if bus ();
        assign bus.req_valid = rv[g];
        assign bus.req_wen   = wen[g];
        assign bus.req_addr  = addr[g];
        assign bus.req_wdata = wdata[g];
        assign bus.req_wmask = wmask[g];
        assign bus.rsp_ready = rr[g];
        assign rq_rdy[g] = bus.req_ready;
        assign rs_v[g]   = bus.rsp_valid;
        assign rs_d[g]   = bus.rsp_rdata;
        assign rs_e[g]   = bus.rsp_err;
        ysyx_25030077_mem_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(L)) u_dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    function automatic int lat_of(input int i);
        return i == 0 ? 2 : i == 1 ? 1 : 15;
    endfunction

    // Drives one request, waits for its response and completes the handshake; lat = edges from accept to rsp_valid
    task automatic run_txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output logic [31:0] rd, output logic er, output int lat);
        int k = 0;
        wen[i] = w; addr[i] = a; wdata[i] = d; wmask[i] = m; rv[i] = 1'b1; rr[i] = 1'b0;
        while (!rq_rdy[i] && k < 50) begin @(posedge clock); #1; k++; end
        @(posedge clock); #1;
        rv[i] = 1'b0;
        lat = 1;
        while (!rs_v[i] && lat < 40) begin @(posedge clock); #1; lat++; end
        if (!rs_v[i] || k >= 50) lat = 99;
        rd = rs_d[i]; er = rs_e[i];
        rr[i] = 1'b1;
        @(posedge clock); #1;
        rr[i] = 1'b0;
    endtask

    task automatic test_reset;
        #3 reset = 1'b0;
        #9;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++; if (rq_rdy[i] !== 1'b0) $display("FAIL reset_req_ready[%0d]: got %b want 0", i, rq_rdy[i]); else pass_cnt++;
            chk_cnt++; if (rs_v[i] !== 1'b0) $display("FAIL reset_rsp_valid[%0d]: got %b want 0", i, rs_v[i]); else pass_cnt++;
            chk_cnt++; if (rs_d[i] !== 32'd0) $display("FAIL reset_rsp_rdata[%0d]: got %h want 0", i, rs_d[i]); else pass_cnt++;
            chk_cnt++; if (rs_e[i] !== 1'b0) $display("FAIL reset_rsp_err[%0d]: got %b want 0", i, rs_e[i]); else pass_cnt++;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk_cnt++; if (rq_rdy !== 3'b111) $display("FAIL release_req_ready: got %b want 111", rq_rdy); else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        q.push_back({1'b0, 32'd0});
        run_txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        e = q.pop_front();
        chk_cnt++; if (lat !== 2) $display("FAIL store_latency: got %0d want 2", lat); else pass_cnt++;
        chk_cnt++; if (er !== e[32]) $display("FAIL store_err: got %b want %b", er, e[32]); else pass_cnt++;
        chk_cnt++; if (rd !== e[31:0]) $display("FAIL store_rdata: got %h want %h", rd, e[31:0]); else pass_cnt++;
        q.push_back({1'b0, 32'hDEAD_BEEF});
        run_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        e = q.pop_front();
        chk_cnt++; if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else pass_cnt++;
        chk_cnt++; if (er !== e[32]) $display("FAIL load_err: got %b want %b", er, e[32]); else pass_cnt++;
        chk_cnt++; if (rd !== e[31:0]) $display("FAIL load_rdata: got %h want %h", rd, e[31:0]); else pass_cnt++;
    endtask

    task automatic test_byte_mask;
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        q.push_back({1'b0, 32'd0});
        run_txn(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, rd, er, lat);
        e = q.pop_front();
        chk_cnt++; if ({er, rd} !== e) $display("FAIL mask_store: got %b/%h want %b/%h", er, rd, e[32], e[31:0]); else pass_cnt++;
        q.push_back({1'b0, 32'hDE22_BE44});
        run_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        e = q.pop_front();
        chk_cnt++; if ({er, rd} !== e) $display("FAIL mask_load: got %b/%h want %b/%h", er, rd, e[32], e[31:0]); else pass_cnt++;
    endtask

    task automatic test_errors;
        logic        tw [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ta [9] = '{32'h8000_0000, 32'h8000_0FFC, 32'h7FFF_FFFC, 32'h8000_1000, 32'h8000_0FFC,
                                32'h8000_0000, 32'h8000_0002, 32'h8000_0010, 32'h8000_0010};
        logic [31:0] td [9] = '{32'h0A0A_0A0A, 32'h5A5A_5A5A, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        logic [3:0]  tm [9] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic        te [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] tr [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h5A5A_5A5A, 32'h0A0A_0A0A, 32'h0, 32'h0, 32'hDE22_BE44};
        logic [31:0] rd; logic er; int lat; logic [32:0] e;
        for (int n = 0; n < 9; n++) begin
            q.push_back({te[n], tr[n]});
            run_txn(0, tw[n], ta[n], td[n], tm[n], rd, er, lat);
            e = q.pop_front();
            chk_cnt++; if (er !== e[32]) $display("FAIL err_case%0d_err: got %b want %b", n, er, e[32]); else pass_cnt++;
            chk_cnt++; if (rd !== e[31:0]) $display("FAIL err_case%0d_rdata: got %h want %h", n, rd, e[31:0]); else pass_cnt++;
            chk_cnt++; if (lat !== 2) $display("FAIL err_case%0d_latency: got %0d want 2", n, lat); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd0; logic er0; logic stable = 1'b1, busy = 1'b1; int k = 0; logic [32:0] e;
        q.push_back({1'b0, 32'hDE22_BE44});
        wen[0] = 1'b0; addr[0] = 32'h8000_0010; wmask[0] = 4'h0; rv[0] = 1'b1; rr[0] = 1'b0;
        @(posedge clock); #1;
        rv[0] = 1'b0;
        while (!rs_v[0] && k < 40) begin @(posedge clock); #1; k++; end
        rd0 = rs_d[0]; er0 = rs_e[0];
        repeat (5) begin
            @(posedge clock); #1;
            if (rs_v[0] !== 1'b1 || rs_d[0] !== rd0 || rs_e[0] !== er0) stable = 1'b0;
            if (rq_rdy[0] !== 1'b0) busy = 1'b0;
        end
        e = q.pop_front();
        chk_cnt++; if ({er0, rd0} !== e) $display("FAIL bp_data: got %b/%h want %b/%h", er0, rd0, e[32], e[31:0]); else pass_cnt++;
        chk_cnt++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b want 1", stable); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL bp_req_ready_low: got %b want 1", busy); else pass_cnt++;
        rr[0] = 1'b1;
        #1;
        chk_cnt++; if (rq_rdy[0] !== 1'b0) $display("FAIL bp_no_overlap: got %b want 0", rq_rdy[0]); else pass_cnt++;
        @(posedge clock); #1;
        rr[0] = 1'b0;
        chk_cnt++; if (rs_v[0] !== 1'b0) $display("FAIL bp_done_valid: got %b want 0", rs_v[0]); else pass_cnt++;
        chk_cnt++; if (rq_rdy[0] !== 1'b1) $display("FAIL bp_done_ready: got %b want 1", rq_rdy[0]); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat; logic [32:0] e; logic seen = 1'b0, rdy = 1'b0;
        q.push_back({1'b0, 32'd0});
        run_txn(2, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, rd, er, lat);
        e = q.pop_front();
        chk_cnt++; if ({er, rd} !== e) $display("FAIL rmid_prestore: got %b/%h want %b/%h", er, rd, e[32], e[31:0]); else pass_cnt++;
        wen[2] = 1'b1; addr[2] = 32'h8000_0020; wdata[2] = 32'hAAAA_AAAA; wmask[2] = 4'hF; rv[2] = 1'b1;
        @(posedge clock); #1;
        rv[2] = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (rs_v[2] !== 1'b0) seen = 1'b1;
            if (rq_rdy !== 3'b000) rdy = 1'b1;
        end
        chk_cnt++; if (rdy !== 1'b0) $display("FAIL rmid_req_ready: got %b want 0", rdy); else pass_cnt++;
        reset = 1'b1;
        repeat (20) begin
            @(posedge clock); #1;
            if (rs_v[2] !== 1'b0) seen = 1'b1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL rmid_rsp_valid: got %b want 0", seen); else pass_cnt++;
        chk_cnt++; if (rq_rdy[2] !== 1'b1) $display("FAIL rmid_release_ready: got %b want 1", rq_rdy[2]); else pass_cnt++;
        q.push_back({1'b0, 32'h1234_5678});
        run_txn(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
        e = q.pop_front();
        chk_cnt++; if ({er, rd} !== e) $display("FAIL rmid_load: got %b/%h want %b/%h", er, rd, e[32], e[31:0]); else pass_cnt++;
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d, er_rd; logic er, w, e_err; logic [3:0] m; int lat, j, r; logic [32:0] e;
        for (int i = 1; i < 3; i++) begin
            for (int n = 0; n < 116; n++) begin
                if (n < 16) begin
                    w = 1'b1; a = BASE + 32'(4 * n); d = $urandom; m = 4'hF;
                end else begin
                    r = $urandom_range(0, 9);
                    w = 1'($urandom_range(0, 1)); d = $urandom; m = 4'($urandom_range(0, 15));
                    a = r == 0 ? BASE - 32'd4 :
                        r == 1 ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3)) :
                        r == 2 ? BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3)) :
                                 BASE + 32'(4 * $urandom_range(0, 15));
                end
                e_err = a < BASE || a >= BASE + 32'h1000 || a[1:0] != 2'b00;
                er_rd = 32'd0;
                if (!e_err) begin
                    j = int'((a - BASE) >> 2);
                    if (w) begin
                        for (int b = 0; b < 4; b++) if (m[b]) mdl[i][j][8*b +: 8] = d[8*b +: 8];
                    end else er_rd = mdl[i][j];
                end
                q.push_back({e_err, er_rd});
                run_txn(i, w, a, d, m, rd, er, lat);
                e = q.pop_front();
                chk_cnt++; if (lat !== lat_of(i)) $display("FAIL rnd%0d_%0d_latency: got %0d want %0d", i, n, lat, lat_of(i)); else pass_cnt++;
                chk_cnt++; if (er !== e[32]) $display("FAIL rnd%0d_%0d_err: got %b want %b addr %h", i, n, er, e[32], a); else pass_cnt++;
                chk_cnt++; if (rd !== e[31:0]) $display("FAIL rnd%0d_%0d_rdata: got %h want %h addr %h", i, n, rd, e[31:0], a); else pass_cnt++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; rv = '0; wen = '0; rr = '0; addr = '0; wdata = '0; wmask = '0;
        test_reset;
        test_store_load;
        test_byte_mask;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
